icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the datapath's instruction port and the memory controller.
- Responder side of the datapath instruction request interface: answers `imemREN`/`imemaddr` with `ihit`/`imemload`.
- Initiator side toward memory: issues `iREN`/`iaddr` and consumes `iwait`/`iload` on misses.
- One-word blocks; a hit returns in the same cycle, a miss stalls the datapath until the fill completes.

---
 rtl/icache_direct.sv | 140 ++++++++++++++
 tb/tb_icache_direct.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache with one-word blocks.  It sits
//   between the datapath instruction port and the memory controller.  A hit
//   is answered combinationally in the same cycle.  A miss enters FETCH and
//   holds the datapath until memory lowers iwait.  The frame is written at
//   that edge, so the following cycle hits.
//
// Ports
//   CLK        in   system clock, rising edge
//   nRST       in   asynchronous active-low reset
//   imemREN    in   datapath instruction read request
//   imemaddr   in   [31:0] instruction byte address (bits [1:0] ignored)
//   ihit       out  requested word is valid on imemload this cycle
//   imemload   out  [31:0] instruction word (0 when not hitting)
//   flush      in   synchronous invalidate of every frame, forces IDLE
//   iREN       out  memory read request
//   iaddr      out  [31:0] memory word address, bits [1:0] = 0
//   iwait      in   memory busy; low means iload is valid this cycle
//   iload      in   [31:0] memory read data
// ---------------------------------------------------------------------------
module icache_direct #(
   parameter int NSETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        flush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int IDXW = $clog2(NSETS);
   localparam int TAGW = 30 - IDXW;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [NSETS-1:0]   r_valid;
   logic [TAGW-1:0]    r_tag  [NSETS];
   logic [31:0]        r_data [NSETS];

   logic [IDXW-1:0]    w_index;
   logic [TAGW-1:0]    w_tag;
   logic               w_hit;
   logic               w_fill;
   logic [NSETS-1:0]   w_frame_sel;
   logic               w_unused;

   assign w_index  = imemaddr[IDXW+1:2];
   assign w_tag    = imemaddr[31:IDXW+2];
   // Byte offset within the word never matters for a word-wide cache.
   assign w_unused = ^imemaddr[1:0];

   assign w_hit    = imemREN & r_valid[w_index] & (r_tag[w_index] == w_tag);
   assign imemload = w_hit ? r_data[w_index] : 32'd0;

   // A fill completes only while the request is still live.  A flush in the
   // same cycle wins, so the frame is never written or marked valid.
   assign w_fill   = (r_state == FETCH) & imemREN & ~iwait & ~flush;

   // One-hot decode of the addressed frame.
   genvar gi;
   generate
      for (gi = 0; gi < NSETS; gi++) begin : g_frame_sel
         assign w_frame_sel[gi] = (w_index == IDXW'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      ihit         = 1'b0;
      iREN         = 1'b0;
      iaddr        = 32'd0;
      case (r_state)
         IDLE: begin
            ihit = w_hit & ~flush;
            if (imemREN & ~w_hit & ~flush) begin
               w_state_next = FETCH;
            end
         end
         FETCH: begin
            // The address follows imemaddr combinationally, so a redirect
            // mid-fetch fills the address present in the completion cycle.
            iREN  = imemREN & ~flush;
            iaddr = {imemaddr[31:2], 2'b00};
            if (flush | ~imemREN | ~iwait) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Valid bits: cleared by reset or flush, set by a completing fill
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_valid <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else if (w_fill) begin
         r_valid <= r_valid | w_frame_sel;
      end
   end

   // Tag and data need no reset: they are only trusted behind a valid bit.
   always_ff @(posedge CLK) begin
      if (w_fill) begin
         r_tag[w_index]  <= w_tag;
         r_data[w_index] <= iload;
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        flush;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   int total = 0;
   int bad   = 0;

   icache_direct dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .flush    (flush),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: which word address each of the 16 frames holds.
   bit          m_valid [16];
   logic [31:0] m_waddr [16];
   logic [31:0] m_word  [16];

   function automatic int m_idx(input logic [31:0] a);
      return int'((a >> 2) % 16);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return m_valid[m_idx(a)] && (m_waddr[m_idx(a)] == {a[31:2], 2'b00});
   endfunction

   task automatic m_fill(input logic [31:0] a, input logic [31:0] w);
      m_valid[m_idx(a)] = 1'b1;
      m_waddr[m_idx(a)] = {a[31:2], 2'b00};
      m_word[m_idx(a)]  = w;
   endtask

   task automatic m_clear();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   function automatic logic [31:0] mem_of(input logic [31:0] a);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      return (wa * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   // Drives one read.  A miss is served with lat busy cycles, then the word.
   // Observations only; every caller does its own comparisons.
   task automatic read_word(input logic [31:0] addr, input int lat, input logic [31:0] word,
                            output bit hit0, output logic [31:0] fa, output bit ren_ok,
                            output int extra, output logic [31:0] dout, output bit tmo);
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = addr; iwait = 1'b1; iload = $urandom;
      #1;
      hit0 = ihit; fa = 32'hFFFF_FFFF; ren_ok = 1'b1; extra = 0; tmo = 1'b0;
      if (!ihit) begin
         if (iREN !== 1'b0) ren_ok = 1'b0;
         @(posedge CLK);
         for (int k = 0; k <= lat; k++) begin
            @(negedge CLK);
            iwait = (k < lat);
            iload = (k < lat) ? $urandom : word;
            #1;
            if (k == 0) fa = iaddr;
            if (iREN !== 1'b1 || iaddr !== {addr[31:2], 2'b00}) ren_ok = 1'b0;
            @(posedge CLK);
         end
         @(negedge CLK);
         iwait = 1'b1; iload = $urandom;
         #1;
         while (!ihit && extra < 8) begin
            @(posedge CLK); @(negedge CLK); #1;
            extra++;
         end
         if (!ihit) tmo = 1'b1;
      end
      dout = imemload;
   endtask

   task automatic test_reset();
      nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0;
      iwait = 1'b1; iload = 32'h1234_5678;
      m_clear();
      repeat (3) @(posedge CLK);
      @(negedge CLK); #1;
      total++; if (ihit !== 1'b0) begin bad++; $display("FAIL reset_ihit got=%b exp=0", ihit); end
      total++; if (iREN !== 1'b0) begin bad++; $display("FAIL reset_iREN got=%b exp=0", iREN); end
      total++; if (imemload !== 32'd0) begin bad++; $display("FAIL reset_imemload got=%h exp=0", imemload); end
      total++; if (iaddr !== 32'd0) begin bad++; $display("FAIL reset_iaddr got=%h exp=0", iaddr); end
      nRST = 1'b1;
      @(posedge CLK);
      @(negedge CLK); #1;
      total++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin
         bad++; $display("FAIL reset_first_fetch got iREN=%b iaddr=%h exp iREN=1 iaddr=00000040", iREN, iaddr);
      end
      // Reset in the middle of a fetch drops the request without a clock.
      #1 nRST = 1'b0;
      #1;
      total++; if (iREN !== 1'b0 || iaddr !== 32'd0) begin
         bad++; $display("FAIL reset_mid_fetch got iREN=%b iaddr=%h exp 0/0", iREN, iaddr);
      end
      @(negedge CLK);
      nRST = 1'b1; imemREN = 1'b0;
      @(posedge CLK);
      $display("reset: done");
   endtask

   task automatic test_cold_miss();
      bit h; logic [31:0] fa, d; bit rok, tmo; int ex;
      read_word(32'h40, 3, 32'h8C22_0004, h, fa, rok, ex, d, tmo);
      total++; if (h !== m_hit(32'h40) || tmo || ex != 0 || !rok || fa !== 32'h40 || d !== 32'h8C22_0004) begin
         bad++; $display("FAIL cold_miss got hit0=%b fa=%h ren_ok=%b extra=%0d data=%h tmo=%b exp hit0=0 fa=00000040 ren_ok=1 extra=0 data=8c220004",
                         h, fa, rok, ex, d, tmo);
      end
      m_fill(32'h40, 32'h8C22_0004);
      for (int r = 0; r < 3; r++) begin
         @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h40 | 32'(r); #1;
         total++; if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== m_word[m_idx(32'h40)]) begin
            bad++; $display("FAIL repeat_hit got ihit=%b iREN=%b data=%h exp 1/0/%h", ihit, iREN, imemload, m_word[m_idx(32'h40)]);
         end
      end
      $display("cold_miss: addr=00000040 data=%h", d);
   endtask

   task automatic test_conflict();
      bit h; logic [31:0] fa, d; bit rok, tmo; int ex; bit exp_h;
      exp_h = m_hit(32'h80);
      read_word(32'h80, 1, 32'hBBBB_0080, h, fa, rok, ex, d, tmo);
      total++; if (h !== exp_h || tmo || !rok || d !== 32'hBBBB_0080) begin
         bad++; $display("FAIL conflict_fill_b got hit0=%b data=%h tmo=%b exp hit0=%b data=bbbb0080", h, d, tmo, exp_h);
      end
      m_fill(32'h80, 32'hBBBB_0080);
      exp_h = m_hit(32'h40);
      read_word(32'h40, 2, 32'hAAAA_0040, h, fa, rok, ex, d, tmo);
      total++; if (h !== exp_h || fa !== 32'h40 || tmo || d !== 32'hAAAA_0040) begin
         bad++; $display("FAIL conflict_evict got hit0=%b fa=%h data=%h exp hit0=%b fa=00000040 data=aaaa0040", h, fa, d, exp_h);
      end
      m_fill(32'h40, 32'hAAAA_0040);
      $display("conflict: 0x80 then 0x40 re-missed=%b", ~h);
   endtask

   task automatic test_abort();
      bit h; logic [31:0] fa, d; bit rok, tmo; int ex; bit exp_h;
      @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1; #1;
      total++; if (ihit !== 1'b0) begin bad++; $display("FAIL abort_miss got ihit=%b exp=0", ihit); end
      @(posedge CLK);
      @(negedge CLK); #1;
      total++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin
         bad++; $display("FAIL abort_fetch got iREN=%b iaddr=%h exp 1/00000100", iREN, iaddr);
      end
      @(posedge CLK);
      @(negedge CLK); imemREN = 1'b0; iwait = 1'b0; iload = 32'hDEAD_BEEF; #1;
      total++; if (iREN !== 1'b0) begin bad++; $display("FAIL abort_ren got=%b exp=0", iREN); end
      @(posedge CLK);
      @(negedge CLK); iwait = 1'b1;
      exp_h = m_hit(32'h100);
      read_word(32'h100, 1, mem_of(32'h100), h, fa, rok, ex, d, tmo);
      total++; if (h !== exp_h || d !== mem_of(32'h100) || tmo) begin
         bad++; $display("FAIL abort_no_fill got hit0=%b data=%h exp hit0=%b data=%h", h, d, exp_h, mem_of(32'h100));
      end
      m_fill(32'h100, mem_of(32'h100));
      $display("abort: re-read 0x100 hit0=%b", h);
   endtask

   task automatic test_redirect();
      bit h; logic [31:0] fa, d; bit rok, tmo; int ex; bit exp_h;
      @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1; #1;
      @(posedge CLK);
      @(negedge CLK); #1;
      total++; if (iaddr !== 32'h10) begin bad++; $display("FAIL redirect_first got iaddr=%h exp=00000010", iaddr); end
      @(posedge CLK);
      @(negedge CLK); imemaddr = 32'h24; #1;
      total++; if (iREN !== 1'b1 || iaddr !== 32'h24) begin
         bad++; $display("FAIL redirect_track got iREN=%b iaddr=%h exp 1/00000024", iREN, iaddr);
      end
      @(posedge CLK);
      @(negedge CLK); iwait = 1'b0; iload = 32'h2424_2424;
      @(posedge CLK);
      m_fill(32'h24, 32'h2424_2424);
      @(negedge CLK); iwait = 1'b1; #1;
      total++; if (ihit !== 1'b1 || imemload !== 32'h2424_2424) begin
         bad++; $display("FAIL redirect_fill got ihit=%b data=%h exp 1/24242424", ihit, imemload);
      end
      exp_h = m_hit(32'h10);
      read_word(32'h10, 0, mem_of(32'h10), h, fa, rok, ex, d, tmo);
      total++; if (h !== exp_h || tmo || d !== mem_of(32'h10)) begin
         bad++; $display("FAIL redirect_idx4 got hit0=%b data=%h exp hit0=%b data=%h", h, d, exp_h, mem_of(32'h10));
      end
      m_fill(32'h10, mem_of(32'h10));
      $display("redirect: 0x10 -> 0x24 filled");
   endtask

   task automatic test_flush();
      bit h; logic [31:0] fa, d; bit rok, tmo; int ex; bit exp_h;
      logic [31:0] a;
      for (int j = 0; j < 2; j++) begin
         a = 32'h40 + 32'(4 * j);
         read_word(a, 1, mem_of(a), h, fa, rok, ex, d, tmo);
         m_fill(a, mem_of(a));
      end
      @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b1; #1;
      total++; if (ihit !== 1'b0 || iREN !== 1'b0) begin
         bad++; $display("FAIL flush_outputs got ihit=%b iREN=%b exp 0/0", ihit, iREN);
      end
      @(posedge CLK);
      m_clear();
      @(negedge CLK); flush = 1'b0; imemREN = 1'b0;
      for (int j = 0; j < 2; j++) begin
         a = 32'h40 + 32'(4 * j);
         exp_h = m_hit(a);
         read_word(a, 1, mem_of(a), h, fa, rok, ex, d, tmo);
         total++; if (h !== exp_h || tmo || d !== mem_of(a)) begin
            bad++; $display("FAIL flush_remiss addr=%h got hit0=%b data=%h exp hit0=%b data=%h", a, h, d, exp_h, mem_of(a));
         end
         m_fill(a, mem_of(a));
      end
      // Flush landing on the fill-completion edge leaves the frame invalid.
      @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h48; iwait = 1'b1;
      @(posedge CLK);
      @(negedge CLK); iwait = 1'b0; iload = 32'h4848_4848; flush = 1'b1; #1;
      total++; if (iREN !== 1'b0) begin bad++; $display("FAIL flush_fill_ren got=%b exp=0", iREN); end
      @(posedge CLK);
      m_clear();
      @(negedge CLK); flush = 1'b0; imemREN = 1'b0; iwait = 1'b1;
      exp_h = m_hit(32'h48);
      read_word(32'h48, 2, mem_of(32'h48), h, fa, rok, ex, d, tmo);
      total++; if (h !== exp_h || tmo || d !== mem_of(32'h48)) begin
         bad++; $display("FAIL flush_coincident got hit0=%b data=%h exp hit0=%b data=%h", h, d, exp_h, mem_of(32'h48));
      end
      m_fill(32'h48, mem_of(32'h48));
      $display("flush: done");
   endtask

   task automatic test_random();
      bit h; logic [31:0] fa, d; bit rok, tmo; int ex; bit exp_h;
      logic [31:0] a, w;
      int lat;
      for (int n = 0; n < 48; n++) begin
         if ($urandom_range(7) == 0) begin
            @(negedge CLK); imemREN = 1'b0; flush = 1'b1;
            @(posedge CLK);
            m_clear();
            @(negedge CLK); flush = 1'b0;
            $display("random: flush");
         end
         a   = (32'($urandom_range(2)) << 6) | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
         lat = int'($urandom_range(3));
         w   = mem_of(a);
         exp_h = m_hit(a);
         read_word(a, lat, w, h, fa, rok, ex, d, tmo);
         total++; if (h !== exp_h || tmo || d !== w || (!exp_h && (!rok || ex != 0 || fa !== {a[31:2], 2'b00}))) begin
            bad++; $display("FAIL random addr=%h got hit0=%b data=%h fa=%h ren_ok=%b extra=%0d tmo=%b exp hit0=%b data=%h fa=%h",
                            a, h, d, fa, rok, ex, tmo, exp_h, w, {a[31:2], 2'b00});
         end
         $display("random: addr=%h lat=%0d hit0=%b data=%h", a, lat, h, d);
         if (!exp_h) m_fill(a, w);
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_conflict();
      test_abort();
      test_redirect();
      test_flush();
      test_random();
      @(negedge CLK); imemREN = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
